// File: rtl/keypad_scanner_if.sv
// Keypad and entry-buffer signal bundle. The scanner uses the master view;
// the keypad matrix and display side use the slave view.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, d1, d2, d3, d4
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, d1, d2, d3, d4
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and 4-digit BCD entry.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV = 8192,
  parameter int DEBOUNCE = 4
) (
  input logic              clk,
  input logic              clr_n,
  keypad_scanner_if.master kp
);
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       d1_q, d2_q, d3_q, d4_q;
  logic [3:0]       d1_d, d2_d, d3_d, d4_d;
  logic             tick, one_low, accept, rpt_fire;
  logic [3:0]       acc_code;

  function automatic logic [3:0] key_map(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    case (pat)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign one_low  = $onehot(~row_sync_q);
  // In SCAN the pattern has not been latched yet, so map the live sample.
  assign acc_code = key_map((state_q == S_SCAN) ? row_sync_q : pat_q, idx_q);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    idx_d       = idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    d4_d        = d4_q;
    accept      = 1'b0;

    case (state_q)
      S_SCAN: if (tick) begin
        if (one_low) begin
          pat_d = row_sync_q;
          cnt_d = 4'd1;
          if (DEBOUNCE == 1) begin
            accept  = 1'b1;
            state_d = S_PRESSED;
          end else begin
            state_d = S_DEBOUNCE;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DEBOUNCE: if (tick) begin
        if (row_sync_q == pat_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == DB_LAST) begin
            accept  = 1'b1;
            state_d = S_PRESSED;
          end
        end else begin
          state_d = S_SCAN;
          idx_d   = idx_q + 2'd1;
        end
      end
      S_PRESSED: if (tick) begin
        if (row_sync_q == 4'hF) begin
          cnt_d = 4'd1;
          if (DEBOUNCE == 1) begin
            state_d = S_SCAN;
            idx_d   = idx_q + 2'd1;
          end else begin
            state_d = S_RELEASE;
          end
        end else if (rpt_fire) begin
          accept = 1'b1;
        end
      end
      S_RELEASE: if (tick) begin
        if (row_sync_q == 4'hF) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == DB_LAST) begin
            state_d = S_SCAN;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          state_d = S_PRESSED;
        end
      end
      default: state_d = S_SCAN;
    endcase

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = acc_code;
      if (acc_code <= 4'd9) begin
        d1_d = d2_q;
        d2_d = d3_q;
        d3_d = d4_q;
        d4_d = acc_code;
      end else if (acc_code == 4'hC) begin
        d1_d = '0;
        d2_d = '0;
        d3_d = '0;
        d4_d = '0;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0] rpt_q, rpt_d, rpt_inc;
  logic       rpt_first_q, rpt_first_d;

  // Held at zero outside PRESSED/RELEASE, so entry to PRESSED from an accept starts fresh,
  // while a return from RELEASE keeps the count.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    rpt_inc     = rpt_q + 8'd1;
    if (state_q == S_SCAN || state_q == S_DEBOUNCE) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == S_PRESSED && tick && row_sync_q != 4'hF) begin
      if (rpt_inc == (rpt_first_q ? 8'd128 : 8'd32)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_SCAN;
      div_q       <= '0;
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      idx_q       <= '0;
      pat_q       <= 4'hF;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      d4_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      div_q       <= div_d;
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      d4_q        <= d4_d;
    end
  end

  assign kp.col       = ~(4'b0001 << idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == S_PRESSED) || (state_q == S_RELEASE);
  assign kp.d1        = d1_q;
  assign kp.d2        = d2_q;
  assign kp.d3        = d3_q;
  assign kp.d4        = d4_q;
endmodule
